module_event_fifo: RTL and testbench
====================================

Name: module_event_fifo

Overview:
- Event-aware output buffer placed directly downstream of the module decoder. Runs on the same 80 MHz domain.
- Accepts the decoder's 16-bit words (qualified by `write`) and stores them in a first-word-fall-through FIFO. Hands them to the readout side over a valid/ready handshake.
- Protects event framing: drops whole events when space is short at event start, and truncates cleanly while keeping the trailer when space runs out mid-event.

Parameters:
- ADDR_WIDTH, 8, FIFO depth = 2**ADDR_WIDTH words.
- MIN_FREE, 16, minimum free slots required to accept a new event at its header word.

Ports:
- clk80  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- write  input  1  word strobe from decoder.
- din  input  16  decoder word; din[15:13] = mode qualifier.
- dout  output  16  FIFO head word, valid when dout_valid=1.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts head word this cycle.
- level  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- dropped  output  8  count of events dropped, saturating at 255.
- truncated  output  1  sticky: at least one event truncated since reset.

Behaviour:
- Reset values: dout_valid=0, level=0, dropped=0, truncated=0, state=IDLE, read/write pointers=0. dout value is don't-care while dout_valid=0.
- Word classes by mode din[15:13]:
  - 101 = event start (TBM header word).
  - 110 = event end (second TBM trailer word).
  - all other modes = body.
- free = 2**ADDR_WIDTH - level, sampled at the start of the cycle. A pop in the same cycle does not add space for a push in that cycle.
- State machine, advancing only on write=1:
  - IDLE:
    - start with free>=MIN_FREE -> push word, go to ACCEPT.
    - start with free<MIN_FREE -> discard, dropped+1 (saturating), go to DROP.
    - any other class -> discard, stay in IDLE.
  - ACCEPT:
    - body with free>=2 -> push.
    - body with free<2 -> discard, set truncated, go to TRUNC.
    - end -> push, go to IDLE.
    - start (missing trailer) -> evaluate exactly as in IDLE; previous event stays unterminated.
  - TRUNC:
    - body -> discard.
    - end -> push with bit 12 forced to 1 (error summary), go to IDLE. The slot is guaranteed by the reservation rule.
    - start -> evaluate as in IDLE.
  - DROP:
    - body -> discard.
    - end -> discard, go to IDLE.
    - start -> evaluate as in IDLE.
- Push/pop:
  - Push writes the RAM at wptr and increments wptr, wrapping modulo depth.
  - Pop occurs when dout_valid & dout_ready and increments rptr.
  - level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: a word pushed at edge N appears on dout with dout_valid=1 after edge N+1 when the FIFO was empty. Otherwise it appears in order behind the existing words.
- Pop while empty: ignored, level stays 0.
- Push into a full FIFO is impossible by construction. The implementation still asserts no write when level==depth.
- dout must not change while dout_valid=1 and dout_ready=0.
- Asynchronous reset mid-event: all state cleared immediately, FIFO contents lost, state returns to IDLE. Body words arriving afterwards are discarded until the next start word.

Test Plan:
- Empty FIFO, event 0xA000, 0x8123, 0x0456, 0xC000 with dout_ready=1 -> same 4 words out in order, level returns to 0, dropped=0, truncated=0.
- dout_ready=0, 240 words already stored (free=16), start word arrives -> event accepted. With free=15 instead -> event discarded, dropped=1, FIFO unchanged.
- dout_ready=0, event with 300 body words into empty FIFO (depth 256) -> level ends at 256, last stored word is the trailer with bit 12 set (e.g. 0xC000 -> 0xD000), truncated=1.
- Body words 0x0111 and trailer 0xC000 with no preceding header -> nothing stored, level=0.
- Full FIFO with dout_ready toggling while a new event's words arrive -> no word lost or duplicated, dout stable while stalled, level matches push/pop count each cycle.
- Assert reset mid-event after 5 words -> level=0, dout_valid=0, dropped=0 immediately. Remaining body words discarded; next header accepted normally.

Source files
------------

// File: rtl/module_event_fifo.sv
// module_event_fifo: event-framing first-word-fall-through output buffer behind the module decoder.
// Ports: clk80/reset (async, active-high); write/din decoder word strobe and data (din[15:13] = mode);
//        dout/dout_valid/dout_ready head-of-FIFO handshake; level occupancy; dropped saturating count
//        of events refused at header time; truncated sticky flag for events cut short mid-stream.
module module_event_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int MIN_FREE   = 16
) (
    input  logic                  clk80,
    input  logic                  reset,
    input  logic                  write,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [7:0]            dropped,
    output logic                  truncated
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] MIN_L   = (ADDR_WIDTH + 1)'(MIN_FREE);
    localparam logic [ADDR_WIDTH:0] TWO_L   = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);
    typedef enum logic [1:0] {IDLE, ACCEPT, TRUNC, DROP} state_t;
    state_t                state, state_next;
    logic [15:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr, raddr;
    logic [ADDR_WIDTH:0]   free;
    logic [15:0]           wdata;
    logic                  push, pop, wen, is_start, is_end, drop_event, trunc_event;

    assign free     = DEPTH_L - level;
    assign is_start = din[15:13] == 3'b101;
    assign is_end   = din[15:13] == 3'b110;
    assign pop      = dout_valid & dout_ready;
    assign wen      = push & (level != DEPTH_L);
    // Read one word ahead when popping so the output register already holds the next head.
    assign raddr    = rptr + {{(ADDR_WIDTH - 1){1'b0}}, pop};

    always_comb begin
        state_next  = state;
        push        = 1'b0;
        wdata       = din;
        drop_event  = 1'b0;
        trunc_event = 1'b0;
        if (write) begin
            if (is_start) begin
                if (free >= MIN_L) begin
                    push       = 1'b1;
                    state_next = ACCEPT;
                end else begin
                    drop_event = 1'b1;
                    state_next = DROP;
                end
            end else if (state == ACCEPT) begin
                if (is_end) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else if (free >= TWO_L) begin
                    push = 1'b1;
                end else begin
                    trunc_event = 1'b1;
                    state_next  = TRUNC;
                end
            end else if (state == TRUNC && is_end) begin
                // Trailer of a cut event carries the error summary bit; its slot was kept free.
                push       = 1'b1;
                wdata[12]  = 1'b1;
                state_next = IDLE;
            end else if (state == DROP && is_end) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk80) begin
        if (wen) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dropped    <= '0;
            truncated  <= 1'b0;
        end else begin
            state <= state_next;
            if (wen) wptr <= wptr + 1;
            if (pop) rptr <= rptr + 1;
            if (wen && !pop) level <= level + 1;
            else if (!wen && pop) level <= level - 1;
            dout       <= mem[raddr];
            dout_valid <= pop ? (level > ONE_L) : (level != '0);
            if (drop_event && dropped != 8'hFF) dropped <= dropped + 1;
            if (trunc_event) truncated <= 1'b1;
        end
    end
endmodule

// File: tb/tb_module_event_fifo.sv
// tb_module_event_fifo: randomized scoreboard bench for module_event_fifo with a queue-based event model.
module tb_module_event_fifo;
    localparam int DEPTH    = 256;
    localparam int MIN_FREE = 16;
    logic        clk80 = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [15:0] din = '0;
    logic        dout_ready = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic [8:0]  level;
    logic [7:0]  dropped;
    logic        truncated;

    module_event_fifo #(.ADDR_WIDTH(8), .MIN_FREE(MIN_FREE)) dut (
        .clk80(clk80), .reset(reset), .write(write), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .dropped(dropped), .truncated(truncated)
    );

    always #6 clk80 = ~clk80;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          mst = 0;
    int          m_dropped = 0;
    bit          m_trunc = 0;
    bit          pend_push = 0, pend_drop = 0, pend_trunc = 0;
    logic [15:0] pend_word = '0;
    int          rdy_mode = 0;
    int          n_out = 0;
    logic [15:0] last_dut = '0;
    bit          stalled = 0;
    logic [15:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk80) begin
        if (reset) begin
            stalled = 0;
        end else begin
            check("level", 32'(level), 32'(exp_q.size()));
            check("dropped", 32'(dropped), 32'(m_dropped));
            check("truncated", 32'(truncated), 32'(m_trunc));
            if (stalled) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_dout", 32'(dout), 32'(held));
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: got word %0h expected no word", dout);
                end else if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL data: got %0h expected %0h", dout, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                last_dut = dout;
                n_out++;
            end
            stalled = dout_valid && !dout_ready;
            held    = dout;
        end
    end

    // Reference: classify each word and decide from the free space seen at the start of the cycle.
    task automatic model(input logic [15:0] d);
        int free;
        free = DEPTH - exp_q.size();
        if (d[15:13] == 3'b101) begin
            if (free >= MIN_FREE) begin
                pend_push = 1; pend_word = d; mst = 1;
            end else begin
                pend_drop = 1; mst = 3;
            end
        end else if (mst == 1) begin
            if (d[15:13] == 3'b110) begin
                pend_push = 1; pend_word = d; mst = 0;
            end else if (free >= 2) begin
                pend_push = 1; pend_word = d;
            end else begin
                pend_trunc = 1; mst = 2;
            end
        end else if (mst == 2 && d[15:13] == 3'b110) begin
            pend_push = 1; pend_word = d | 16'h1000; mst = 0;
        end else if (mst == 3 && d[15:13] == 3'b110) begin
            mst = 0;
        end
    endtask

    task automatic tick(input bit w, input logic [15:0] d);
        @(posedge clk80);
        #1;
        if (pend_push) exp_q.push_back(pend_word);
        if (pend_drop && m_dropped < 255) m_dropped++;
        if (pend_trunc) m_trunc = 1;
        pend_push = 0; pend_drop = 0; pend_trunc = 0;
        dout_ready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 :
                     rdy_mode == 2 ? 1'($urandom_range(0, 1)) : !dout_ready;
        write = w;
        din   = d;
        if (w) model(d);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 16'h0);
    endtask

    task automatic do_reset();
        @(posedge clk80);
        #1;
        reset = 1; write = 0;
        exp_q.delete();
        mst = 0; m_dropped = 0; m_trunc = 0;
        pend_push = 0; pend_drop = 0; pend_trunc = 0;
        #1;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_truncated", 32'(truncated), 32'd0);
        @(posedge clk80);
        #1;
        reset = 0;
    endtask

    task automatic drain();
        int i;
        rdy_mode = 1;
        for (i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && !pend_push && !dout_valid && level == 0) break;
            tick(0, 16'h0);
        end
        check("drain_done", 32'(exp_q.size() + int'(level)), 32'd0);
    endtask

    function automatic logic [15:0] body_word();
        logic [2:0] m;
        m = 3'($urandom_range(0, 5));
        if (m == 3'd5) m = 3'd7;
        return {m, 13'($urandom)};
    endfunction

    function automatic logic [15:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8) return {3'b101, 13'($urandom)};
        if (r < 16) return {3'b110, 13'($urandom)};
        return body_word();
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (2) @(posedge clk80);
        #1;
        check("init_valid", 32'(dout_valid), 32'd0);
        check("init_level", 32'(level), 32'd0);
        check("init_dropped", 32'(dropped), 32'd0);
        check("init_truncated", 32'(truncated), 32'd0);
        reset = 0;

        // Basic event, consumer always ready.
        rdy_mode = 1;
        n0 = n_out;
        tick(1, 16'hA000);
        tick(1, 16'h8123);
        check("latency_early", 32'(dout_valid), 32'd0);
        tick(1, 16'h0456);
        check("latency_valid", 32'(dout_valid), 32'd1);
        check("latency_head", 32'(dout), 32'hA000);
        tick(1, 16'hC000);
        drain();
        check("basic_count", 32'(n_out - n0), 32'd4);
        check("basic_last", 32'(last_dut), 32'hC000);
        check("basic_dropped", 32'(dropped), 32'd0);
        check("basic_trunc", 32'(truncated), 32'd0);

        // Exactly MIN_FREE free slots: header accepted.
        do_reset();
        rdy_mode = 0;
        tick(1, 16'hA001);
        repeat (238) tick(1, body_word());
        tick(1, 16'hC001);
        idle(2);
        check("fill240", 32'(level), 32'd240);
        tick(1, 16'hA002);
        tick(1, body_word());
        tick(1, 16'hC002);
        idle(2);
        check("free16_accept", 32'(level), 32'd243);
        check("free16_dropped", 32'(dropped), 32'd0);
        drain();

        // One slot short: whole event dropped, then saturate the drop counter.
        do_reset();
        rdy_mode = 0;
        tick(1, 16'hA003);
        repeat (239) tick(1, body_word());
        tick(1, 16'hC003);
        idle(2);
        check("fill241", 32'(level), 32'd241);
        tick(1, 16'hA004);
        tick(1, body_word());
        tick(1, 16'hC004);
        idle(2);
        check("free15_level", 32'(level), 32'd241);
        check("free15_dropped", 32'(dropped), 32'd1);
        for (int i = 0; i < 300; i++) tick(1, {3'b101, 13'(i)});
        idle(2);
        check("drop_saturate", 32'(dropped), 32'd255);
        check("drop_level", 32'(level), 32'd241);
        drain();

        // Oversized event truncated, trailer kept with error bit.
        do_reset();
        rdy_mode = 0;
        tick(1, 16'hA005);
        repeat (300) tick(1, body_word());
        tick(1, 16'hC000);
        idle(2);
        check("trunc_level", 32'(level), 32'd256);
        check("trunc_flag", 32'(truncated), 32'd1);
        drain();
        check("trunc_last", 32'(last_dut), 32'hD000);

        // Full FIFO with a toggling consumer while new events stream in.
        rdy_mode = 0;
        tick(1, 16'hA006);
        repeat (270) tick(1, body_word());
        tick(1, 16'hC006);
        idle(1);
        rdy_mode = 3;
        for (int e = 0; e < 6; e++) begin
            tick(1, {3'b101, 13'(e)});
            repeat ($urandom_range(5, 40)) tick(1, body_word());
            tick(1, {3'b110, 13'(e)});
        end
        drain();

        // Orphan body and trailer words are ignored.
        do_reset();
        rdy_mode = 1;
        tick(1, 16'h0111);
        tick(1, 16'hC000);
        idle(3);
        check("orphan_level", 32'(level), 32'd0);
        check("orphan_valid", 32'(dout_valid), 32'd0);

        // Reset in the middle of an event.
        rdy_mode = 0;
        tick(1, 16'hA007);
        repeat (4) tick(1, body_word());
        idle(1);
        check("mid_level", 32'(level), 32'd5);
        do_reset();
        repeat (3) tick(1, body_word());
        idle(2);
        check("post_rst_level", 32'(level), 32'd0);
        tick(1, 16'hA008);
        repeat (2) tick(1, body_word());
        tick(1, 16'hC008);
        idle(2);
        check("post_rst_accept", 32'(level), 32'd4);
        drain();

        // Random traffic with varying consumer behaviour.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) rdy_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 7) tick(1, rand_word());
            else tick(0, 16'h0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
